// File: rtl/rtr_inject_pkg.sv
// rtr_inject_pkg: shared types, default sizes and width helpers for the injection scheduler
package rtr_inject_pkg;
  localparam int DEF_NUM_VCS = 4;
  localparam int DEF_CREDITS_PER_VC = 8;
  localparam int DEF_FLIT_DATA_WIDTH = 32;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  localparam int DEF_VC_IDX_WIDTH = idx_w(DEF_NUM_VCS);
  typedef struct packed {
    logic                           valid;
    logic                           head;
    logic                           tail;
    logic [DEF_VC_IDX_WIDTH-1:0]    vc;
    logic [DEF_FLIT_DATA_WIDTH-1:0] data;
  } flit_t;
  typedef struct packed {
    logic                        valid;
    logic [DEF_VC_IDX_WIDTH-1:0] vc;
  } credit_t;
endpackage

// File: rtl/rtr_rr_arbiter.sv
// rtr_rr_arbiter: round-robin arbiter; req -> one-hot gnt + idx, pointer advances past the winner when upd_en
module rtr_rr_arbiter
  import rtr_inject_pkg::*;
#(
  parameter int N = 4,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          upd_en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic hit;
  int j;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      j = (j >= N) ? j - N : j;
      if (!hit && req[IW'(j)]) begin
        hit = 1'b1;
        idx = IW'(j);
      end
    end
    gnt = hit ? (N'(1) << idx) : '0;
    ptr_d = (upd_en && hit) ? ((int'(idx) == N - 1) ? '0 : idx + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rtr_inject_sched.sv
// rtr_inject_sched: injection-port scheduler sharing one channel among NUM_SRC sources (source i -> VC i)
//   in : clk, reset (sync, active-high), src_valid/head/tail/data, credit_valid/credit_vc
//   out: src_ready (one-hot grant), chan_flit_* (registered flit), credit_avail, error (sticky)
//   INJ_SCHED_PACKET_LOCK_EN: when defined, a granted head without tail locks the channel to that source until its tail
module rtr_inject_sched
  import rtr_inject_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int NUM_VCS = DEF_NUM_VCS,
  parameter int CREDITS_PER_VC = DEF_CREDITS_PER_VC,
  parameter int FLIT_DATA_WIDTH = DEF_FLIT_DATA_WIDTH,
  parameter int VC_IDX_WIDTH = idx_w(NUM_VCS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_SRC-1:0]                 src_valid,
  input  logic [NUM_SRC-1:0]                 src_head,
  input  logic [NUM_SRC-1:0]                 src_tail,
  input  logic [NUM_SRC*FLIT_DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]                 src_ready,
  output logic                               chan_flit_valid,
  output logic                               chan_flit_head,
  output logic                               chan_flit_tail,
  output logic [VC_IDX_WIDTH-1:0]            chan_flit_vc,
  output logic [FLIT_DATA_WIDTH-1:0]         chan_flit_data,
  input  logic                               credit_valid,
  input  logic [VC_IDX_WIDTH-1:0]            credit_vc,
  output logic [NUM_VCS-1:0]                 credit_avail,
  output logic                               error
);
  localparam int CW = cnt_w(CREDITS_PER_VC);
  localparam int SW = idx_w(NUM_SRC);
  localparam logic [CW-1:0] FULL = CW'(CREDITS_PER_VC);
  logic [CW-1:0] cnt_q [NUM_VCS];
  logic [CW-1:0] cnt_d [NUM_VCS];
  logic [NUM_SRC-1:0] open_q, open_d, elig, req, gnt;
  logic [SW-1:0] gidx;
  logic grant, upd_en, sel_head, sel_tail, err_ev, snd, ret;
  logic [FLIT_DATA_WIDTH-1:0] sel_data;
  logic error_q, error_d, fv_q, fv_d, fh_q, fh_d, ft_q, ft_d;
  logic [VC_IDX_WIDTH-1:0] fvc_q, fvc_d;
  logic [FLIT_DATA_WIDTH-1:0] fd_q, fd_d;
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SRC; i++) elig[i] = src_valid[i] && cnt_q[i] != '0;
  end
`ifdef INJ_SCHED_PACKET_LOCK_EN
  logic lock_q, lock_d;
  logic [SW-1:0] lock_src_q, lock_src_d;
  always_comb begin
    req = lock_q ? elig & (NUM_SRC'(1) << lock_src_q) : elig;
    upd_en = ~lock_q;
    lock_d = grant ? (lock_q ? ~sel_tail : sel_head & ~sel_tail) : lock_q;
    lock_src_d = (grant && !lock_q) ? gidx : lock_src_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
      lock_src_q <= '0;
    end else begin
      lock_q <= lock_d;
      lock_src_q <= lock_src_d;
    end
  end
`else
  assign req = elig;
  assign upd_en = 1'b1;
`endif
  rtr_rr_arbiter #(.N(NUM_SRC), .IW(SW)) u_arb (
    .clk(clk), .reset(reset), .req(req), .upd_en(upd_en), .gnt(gnt), .idx(gidx)
  );
  assign grant = |gnt;
  assign src_ready = reset ? '0 : gnt;
  always_comb begin
    sel_head = 1'b0;
    sel_tail = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (int'(gidx) == i) begin
        sel_head = src_head[i];
        sel_tail = src_tail[i];
        sel_data = src_data[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
      end
  end
  always_comb begin
    // packet error: head while already open, or non-head while closed, i.e. head == open
    err_ev = (credit_valid && int'(credit_vc) >= NUM_SRC) || (grant && sel_head == open_q[gidx]);
    snd = 1'b0;
    ret = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      snd = grant && v < NUM_SRC && int'(gidx) == v;
      ret = credit_valid && v < NUM_SRC && int'(credit_vc) == v;
      cnt_d[v] = (snd && !ret) ? cnt_q[v] - 1'b1 :
                 (ret && !snd && cnt_q[v] != FULL) ? cnt_q[v] + 1'b1 : cnt_q[v];
      err_ev = err_ev | (ret && !snd && cnt_q[v] == FULL);
      credit_avail[v] = cnt_q[v] != '0;
    end
    open_d = open_q;
    if (grant) open_d[gidx] = sel_head ? ~sel_tail : open_q[gidx] & ~sel_tail;
    error_d = error_q | err_ev;
    fv_d = grant;
    fh_d = grant ? sel_head : fh_q;
    ft_d = grant ? sel_tail : ft_q;
    fvc_d = grant ? VC_IDX_WIDTH'(gidx) : fvc_q;
    fd_d = grant ? sel_data : fd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VCS; v++) cnt_q[v] <= FULL;
      open_q <= '0;
      error_q <= 1'b0;
      fv_q <= 1'b0;
      fh_q <= 1'b0;
      ft_q <= 1'b0;
      fvc_q <= '0;
      fd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      open_q <= open_d;
      error_q <= error_d;
      fv_q <= fv_d;
      fh_q <= fh_d;
      ft_q <= ft_d;
      fvc_q <= fvc_d;
      fd_q <= fd_d;
    end
  end
  assign chan_flit_valid = fv_q;
  assign chan_flit_head = fh_q;
  assign chan_flit_tail = ft_q;
  assign chan_flit_vc = fvc_q;
  assign chan_flit_data = fd_q;
  assign error = error_q;
endmodule

// File: tb/tb_rtr_inject_sched.sv
// tb_rtr_inject_sched: directed self-checking bench with a behavioural scheduler model
module tb_rtr_inject_sched;
  localparam int NS = 4, NV = 4, CR = 8, DW = 32, VW = 2;
`ifdef INJ_SCHED_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [NS-1:0] src_valid = '0, src_head = '0, src_tail = '0, src_ready;
  logic [NS*DW-1:0] src_data = '0;
  logic chan_flit_valid, chan_flit_head, chan_flit_tail, error;
  logic [VW-1:0] chan_flit_vc;
  logic [DW-1:0] chan_flit_data;
  logic credit_valid = 1'b0;
  logic [VW-1:0] credit_vc = '0;
  logic [NV-1:0] credit_avail, exp_avail;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int m_cnt [NV];
  bit m_open [NS];
  int m_ptr = 0, m_g = -1, m_lsrc = 0, m_fvc = 0, tag = 0;
  bit m_err = 0, m_lock = 0, m_fv = 0, m_fh = 0, m_ft = 0;
  logic [DW-1:0] m_fd = '0;
  logic [NS-1:0] exp_ready = '0, last_ready;
  rtr_inject_sched dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_head(src_head), .src_tail(src_tail),
    .src_data(src_data), .src_ready(src_ready), .chan_flit_valid(chan_flit_valid),
    .chan_flit_head(chan_flit_head), .chan_flit_tail(chan_flit_tail), .chan_flit_vc(chan_flit_vc),
    .chan_flit_data(chan_flit_data), .credit_valid(credit_valid), .credit_vc(credit_vc),
    .credit_avail(credit_avail), .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic model_comb;
    int s;
    m_g = -1;
    if (!reset)
      for (int k = 0; k < NS; k++) begin
        s = (m_ptr + k) % NS;
        if (m_g < 0 && src_valid[s] && m_cnt[s] > 0 && (!m_lock || s == m_lsrc)) m_g = s;
      end
    exp_ready = '0;
    if (m_g >= 0) exp_ready[m_g] = 1'b1;
  endtask
  task automatic model_seq;
    bit h, t, wl, snd, ret;
    if (reset) begin
      foreach (m_cnt[v]) m_cnt[v] = CR;
      foreach (m_open[i]) m_open[i] = 1'b0;
      m_ptr = 0; m_err = 0; m_lock = 0; m_lsrc = 0;
      m_fv = 0; m_fh = 0; m_ft = 0; m_fvc = 0; m_fd = '0;
      return;
    end
    if (credit_valid && int'(credit_vc) >= NS) m_err = 1;
    for (int v = 0; v < NV; v++) begin
      snd = (m_g == v);
      ret = credit_valid && int'(credit_vc) == v && v < NS;
      if (snd && !ret) m_cnt[v]--;
      else if (ret && !snd) begin
        if (m_cnt[v] == CR) m_err = 1;
        else m_cnt[v]++;
      end
    end
    m_fv = (m_g >= 0);
    if (m_g >= 0) begin
      h = src_head[m_g];
      t = src_tail[m_g];
      wl = m_lock;
      if ((h && m_open[m_g]) || (!h && !m_open[m_g])) m_err = 1;
      if (h && !t) m_open[m_g] = 1;
      else if (t) m_open[m_g] = 0;
      if (LOCK) begin
        if (!wl && h && !t) begin m_lock = 1; m_lsrc = m_g; end
        else if (wl && t) m_lock = 0;
      end
      if (!wl) m_ptr = (m_g + 1) % NS;
      m_fh = h; m_ft = t; m_fvc = m_g; m_fd = src_data[m_g*DW +: DW];
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      for (int v = 0; v < NV; v++) exp_avail[v] = m_cnt[v] > 0;
      chk("src_ready", src_ready, exp_ready);
      chk("credit_avail", credit_avail, exp_avail);
      chk("error", error, m_err);
      chk("chan_valid", chan_flit_valid, m_fv);
      chk("chan_head", chan_flit_head, m_fh);
      chk("chan_tail", chan_flit_tail, m_ft);
      chk("chan_vc", chan_flit_vc, m_fvc);
      chk("chan_data", chan_flit_data, m_fd);
    end
  end
  task automatic cyc(input logic [NS-1:0] v, input logic [NS-1:0] h, input logic [NS-1:0] t,
                     input logic cv, input int cvc);
    src_valid = v; src_head = h; src_tail = t;
    credit_valid = cv; credit_vc = VW'(cvc);
    tag++;
    for (int k = 0; k < NS; k++) src_data[k*DW +: DW] = {tag[23:0], 8'(k)};
    model_comb();
    @(negedge clk);
    last_ready = src_ready;
    @(posedge clk);
    model_seq();
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1; src_valid = '1; src_head = '1; src_tail = '1; credit_valid = 1'b0;
    model_comb();
    @(negedge clk);
    last_ready = src_ready;
    @(posedge clk);
    model_seq();
    #1;
    reset = 1'b0;
  endtask
  logic [NS-1:0] e6 [4];
  int n, k;
  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst_ready", last_ready, 0);
    chk("rst_avail", credit_avail, 4'hF);
    chk("rst_chan_valid", chan_flit_valid, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(4'hF, 4'hF, 4'hF, 1'b0, 0);
      chk("t1_grant", last_ready, 64'(1) << (i % 4));
      chk("t1_vc", chan_flit_vc, i % 4);
    end
    for (int v = 0; v < NV; v++) chk("t1_model_cnt", m_cnt[v], 6);
    do_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0100, 4'b0100, 4'b0100, 1'b0, 0);
      if (last_ready == 4'b0100) n++;
    end
    chk("t2_grants", n, 8);
    chk("t2_avail", credit_avail, 4'b1011);
    chk("t2_ready_empty", last_ready, 0);
    cyc(4'b0100, 4'b0100, 4'b0100, 1'b1, 2);
    chk("t2_ready_on_credit", last_ready, 0);
    cyc(4'b0100, 4'b0100, 4'b0100, 1'b0, 0);
    chk("t2_regrant", last_ready, 4'b0100);
    cyc(4'b0100, 4'b0100, 4'b0100, 1'b0, 0);
    chk("t2_after_regrant", last_ready, 0);
    do_reset();
    repeat (3) cyc(4'b0010, 4'b0010, 4'b0010, 1'b0, 0);
    cyc(4'b0010, 4'b0010, 4'b0010, 1'b1, 1);
    chk("t3_grant", last_ready, 4'b0010);
    chk("t3_model_cnt", m_cnt[1], 5);
    chk("t3_err", error, 0);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(4'b0010, 4'b0010, 4'b0010, 1'b0, 0);
      if (last_ready == 4'b0010) n++;
    end
    chk("t3_remaining", n, 5);
    do_reset();
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b1, 0);
    chk("t4_err", error, 1);
    repeat (3) cyc(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    chk("t4_sticky", error, 1);
    chk("t4_avail", credit_avail, 4'hF);
    do_reset();
    chk("t5_err_clear", error, 0);
    cyc(4'b0010, 4'b0010, 4'b0000, 1'b0, 0);
    chk("t5_head_ok", error, 0);
    cyc(4'b0001, 4'b0000, 4'b0000, 1'b0, 0);
    chk("t5_fwd_valid", chan_flit_valid, 1);
    chk("t5_fwd_vc", chan_flit_vc, 0);
    chk("t5_err", error, 1);
    do_reset();
    chk("t5_rst_err", error, 0);
    chk("t5_rst_valid", chan_flit_valid, 0);
    chk("t5_rst_avail", credit_avail, 4'hF);
    cyc(4'b0010, 4'b0000, 4'b0010, 1'b0, 0);
    chk("t5_tail_after_rst", error, 1);
    do_reset();
    if (LOCK) e6 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    else e6 = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    k = 0;
    for (int c = 0; c < 4; c++) begin
      cyc({2'b00, 1'b1, k < 3}, {2'b00, 1'b1, k == 0}, {2'b00, 1'b1, k == 2}, 1'b0, 0);
      chk("t6_grant", last_ready, e6[c]);
      if (last_ready[0]) k++;
    end
    chk("t6_err", error, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
